// File: rtl/column_mask_capture_if.sv
// Pixel-stream and mask-publish signals between the video source and column_mask_capture.
// The master drives pixels and frame control; the slave (capture block) returns the mask.
interface column_mask_capture_if #(
    parameter int unsigned ROWS = 480
);
    logic            frame_start;
    logic [9:0]      col_sel;
    logic            pix_valid;
    logic [9:0]      pix_x;
    logic [9:0]      pix_y;
    logic [23:0]     pix_rgb;
    logic [ROWS-1:0] mask_out;
    logic [9:0]      hit_count;
    logic            mask_valid;
    logic            frame_dropped;

    modport master (
        output frame_start, col_sel, pix_valid, pix_x, pix_y, pix_rgb,
        input  mask_out, hit_count, mask_valid, frame_dropped
    );

    modport slave (
        input  frame_start, col_sel, pix_valid, pix_x, pix_y, pix_rgb,
        output mask_out, hit_count, mask_valid, frame_dropped
    );
endinterface

// File: rtl/column_mask_capture.sv
// Builds a per-row colour-hit mask for one selected column and publishes it once per frame
// together with its population count.
module column_mask_capture #(
    parameter int unsigned ROWS  = 480,
    parameter int unsigned COLS  = 640,
    parameter logic [7:0]  R_MIN = 8'hC0,
    parameter logic [7:0]  G_MAX = 8'h40,
    parameter logic [7:0]  B_MAX = 8'h40
) (
    input logic                   Clk,
    input logic                   Reset,
    column_mask_capture_if.slave  bus
);
    localparam int unsigned YW     = $clog2(ROWS);
    localparam logic [9:0]  LAST_X = 10'(COLS - 1);
    localparam logic [9:0]  LAST_Y = 10'(ROWS - 1);
    localparam logic [9:0]  ROWS_W = 10'(ROWS);

    typedef enum logic [1:0] {StIdle, StCapture, StPublish} state_e;

    state_e          state_q, state_d;
    logic [ROWS-1:0] shadow_q, shadow_d;
    logic [9:0]      count_q, count_d;
    logic [9:0]      col_q, col_d;
    logic [ROWS-1:0] mask_q, mask_d;
    logic [9:0]      hit_q, hit_d;
    logic            valid_q, valid_d;
    logic            dropped_q, dropped_d;

    logic            colour_ok;
    logic            qualify;
    logic            last_pix;
    logic [YW-1:0]   row_idx;

    assign colour_ok = (bus.pix_rgb[23:16] >= R_MIN) && (bus.pix_rgb[15:8] < G_MAX) &&
                       (bus.pix_rgb[7:0] < B_MAX);
    // Row bound check also keeps row_idx in range of the shadow vector.
    assign qualify   = bus.pix_valid && (bus.pix_x == col_q) && (bus.pix_y < ROWS_W) &&
                       colour_ok;
    assign last_pix  = bus.pix_valid && (bus.pix_x == LAST_X) && (bus.pix_y == LAST_Y);
    assign row_idx   = bus.pix_y[YW-1:0];

    always_comb begin
        state_d   = state_q;
        shadow_d  = shadow_q;
        count_d   = count_q;
        col_d     = col_q;
        mask_d    = mask_q;
        hit_d     = hit_q;
        valid_d   = 1'b0;
        dropped_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.frame_start) begin
                    col_d    = bus.col_sel;
                    shadow_d = '0;
                    count_d  = '0;
                    state_d  = StCapture;
                end
            end
            StCapture: begin
                if (bus.frame_start) begin
                    // Truncated frame: restart capture, leave the published mask alone.
                    dropped_d = 1'b1;
                    col_d     = bus.col_sel;
                    shadow_d  = '0;
                    count_d   = '0;
                end else begin
                    if (qualify && !shadow_q[row_idx]) begin
                        shadow_d[row_idx] = 1'b1;
                        count_d           = count_q + 10'd1;
                    end
                    if (last_pix) begin
                        state_d = StPublish;
                    end
                end
            end
            StPublish: begin
                mask_d  = shadow_q;
                hit_d   = count_q;
                valid_d = 1'b1;
                if (bus.frame_start) begin
                    col_d    = bus.col_sel;
                    shadow_d = '0;
                    count_d  = '0;
                    state_d  = StCapture;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= StIdle;
            shadow_q  <= '0;
            count_q   <= '0;
            col_q     <= '0;
            mask_q    <= '0;
            hit_q     <= '0;
            valid_q   <= 1'b0;
            dropped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            shadow_q  <= shadow_d;
            count_q   <= count_d;
            col_q     <= col_d;
            mask_q    <= mask_d;
            hit_q     <= hit_d;
            valid_q   <= valid_d;
            dropped_q <= dropped_d;
        end
    end

    assign bus.mask_out      = mask_q;
    assign bus.hit_count     = hit_q;
    assign bus.mask_valid    = valid_q;
    assign bus.frame_dropped = dropped_q;
endmodule
